// File: rtl/disp_res8b_7seg.sv
// Result-display stage: captures an adder/subtractor result, converts it to BCD by double-dabble,
// and scans a 4-digit common-anode 7-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module disp_res8b_7seg #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  So,
    input  logic        flag,
    input  logic        Sel,
    output logic        busy,
    output logic [11:0] bcd_out,
    output logic        neg_out,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t      state;
    logic [8:0]  mag;
    logic        neg;
    logic [11:0] bcd;
    logic [3:0]  cnt;

    logic [7:0]  so_neg;
    logic [8:0]  cap_mag;
    logic        cap_neg;
    logic [11:0] bcd_adj;

    logic [DW-1:0] div;
    logic [1:0]    idx;
    logic [6:0]    digit_seg;

    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // A borrow on a difference means the result is the two's complement of the true magnitude.
    assign so_neg  = ~So + 8'd1;
    assign cap_mag = !Sel ? {flag, So} : (flag ? {1'b0, so_neg} : {1'b0, So});
    assign cap_neg = Sel & flag;
    assign bcd_adj = {dabble(bcd[11:8]), dabble(bcd[7:4]), dabble(bcd[3:0])};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mag     <= '0;
            neg     <= 1'b0;
            bcd     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            bcd_out <= '0;
            neg_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag   <= cap_mag;
                        neg   <= cap_neg;
                        bcd   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd <= {bcd_adj[10:0], mag[8]};
                    mag <= {mag[7:0], 1'b0};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd8) state <= COMMIT;
                end
                COMMIT: begin
                    bcd_out <= bcd;
                    neg_out <= neg;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        digit_seg = SEG_BLANK;
        case (idx)
            2'd3: digit_seg = neg_out ? SEG_MINUS : SEG_BLANK;
`ifdef LEADING_ZERO_BLANK_EN
            2'd2: digit_seg = (bcd_out[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd_out[11:8]);
            2'd1: digit_seg = (bcd_out[11:4] == 8'd0) ? SEG_BLANK : seg7(bcd_out[7:4]);
`else
            2'd2: digit_seg = seg7(bcd_out[11:8]);
            2'd1: digit_seg = seg7(bcd_out[7:4]);
`endif
            default: digit_seg = seg7(bcd_out[3:0]);
        endcase
    end

    // seg/an load together at the start of each digit period, so no digit ever shows a mid-period change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            idx <= '0;
            seg <= SEG_BLANK;
            an  <= 4'b1111;
        end else begin
            if (div == DIV_LAST) begin
                div <= '0;
                idx <= idx + 2'd1;
            end else begin
                div <= div + 1'b1;
            end
            if (div == '0) begin
                an  <= ~(4'b0001 << idx);
                seg <= digit_seg;
            end
        end
    end

endmodule

// File: tb/tb_disp_res8b_7seg.sv
// Self-checking bench for disp_res8b_7seg: table vectors, random vectors against a decimal model,
// and hand sequences for reset, busy rejection and scan order. Honours LEADING_ZERO_BLANK_EN.
module tb_disp_res8b_7seg;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  So = '0;
    logic        flag = 1'b0;
    logic        Sel = 1'b0;
    logic        busy;
    logic [11:0] bcd_out;
    logic        neg_out;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        s;
        logic        f;
        logic [7:0]  so;
        logic [11:0] bcd;
        logic        neg;
    } vec_t;

    vec_t vecs[9];
    logic [6:0] seg_tab[10];
    logic [11:0] prev_bcd;

    disp_res8b_7seg #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .So(So), .flag(flag), .Sel(Sel),
        .busy(busy), .bcd_out(bcd_out), .neg_out(neg_out), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain decimal arithmetic on the signed-magnitude interpretation.
    task automatic model(input logic s, input logic f, input logic [7:0] so,
                         output logic [11:0] bcd, output logic neg);
        int m;
        if (!s) m = int'(f) * 256 + int'(so);
        else if (f) m = (256 - int'(so)) % 256;
        else m = int'(so);
        neg = s & f;
        bcd = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endtask

    function automatic logic [6:0] exp_seg(input int pos, input logic [11:0] bcd, input logic neg);
        int h, t, u;
        h = int'(bcd[11:8]); t = int'(bcd[7:4]); u = int'(bcd[3:0]);
        if (pos == 3) return neg ? 7'b0111111 : 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
        if (pos == 2 && h == 0) return 7'b1111111;
        if (pos == 1 && h == 0 && t == 0) return 7'b1111111;
`endif
        if (pos == 2) return seg_tab[h];
        if (pos == 1) return seg_tab[t];
        return seg_tab[u];
    endfunction

    task automatic apply_stimulus(input logic s, input logic f, input logic [7:0] so,
                                  input logic [11:0] exp_bcd, input logic exp_neg);
        int lo;
        @(negedge clk);
        Sel = s; flag = f; So = so; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_output("busy_at_capture", 32'(busy), 32'd1);
        lo = 0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (!busy) lo++;
        end
        check_output("busy_during_shift", 32'(lo), 32'd0);
        check_output("bcd_held_until_commit", 32'(bcd_out), 32'(prev_bcd));
        @(posedge clk); #1;
        check_output("busy_after_commit", 32'(busy), 32'd0);
        check_output("bcd_out", 32'(bcd_out), 32'(exp_bcd));
        check_output("neg_out", 32'(neg_out), 32'(exp_neg));
        prev_bcd = exp_bcd;
    endtask

    // Let the new value reach every digit, then capture one full scan.
    task automatic check_display(input logic [11:0] bcd, input logic neg);
        logic [6:0] seen[4];
        logic [3:0] seen_ok;
        seen_ok = '0;
        for (int p = 0; p < 4; p++) seen[p] = 7'h00;
        repeat (2 * 4 * DIV) @(posedge clk);
        for (int c = 0; c < 4 * DIV; c++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 4; p++)
                if (an == ~(4'b0001 << p)) begin seen[p] = seg; seen_ok[p] = 1'b1; end
        end
        check_output("all_digits_scanned", 32'(seen_ok), 32'hf);
        for (int p = 0; p < 4; p++)
            check_output($sformatf("seg_digit%0d", p), 32'(seen[p]), 32'(exp_seg(p, bcd, neg)));
    endtask

    initial begin
        logic [3:0]  exp_an[5];
        logic [3:0]  prev_an;
        logic [6:0]  prev_seg;
        int          bad_an, bad_seg;
        logic [11:0] mb;
        logic        mn;
        logic        rs, rf;
        logic [7:0]  rso;

        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        vecs[0] = '{1'b0, 1'b1, 8'hFE, 12'h510, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 8'hF6, 12'h010, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 8'h00, 12'h000, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 8'hFF, 12'h255, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 12'h256, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 8'h01, 12'h255, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 8'h00, 12'h000, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 8'h63, 12'h099, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 8'h80, 12'h128, 1'b1};
        exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        prev_bcd = 12'h000;

        #12;
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_bcd", 32'(bcd_out), 32'd0);
        check_output("reset_seg", 32'(seg), 32'h7f);
        check_output("reset_an", 32'(an), 32'hf);

        // Scan order straight out of reset: each digit held exactly DIV cycles.
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("first_edge_an", 32'(an), 32'b1110);
        check_output("first_edge_seg", 32'(seg), 32'(exp_seg(0, 12'h000, 1'b0)));
        bad_an = (an != exp_an[0]) ? 1 : 0;
        bad_seg = 0;
        prev_an = an; prev_seg = seg;
        for (int e = 1; e < 5 * DIV; e++) begin
            @(posedge clk); #1;
            if (an != exp_an[e / DIV]) bad_an++;
            if (an == prev_an && seg != prev_seg) bad_seg++;
            prev_an = an; prev_seg = seg;
        end
        check_output("scan_order", 32'(bad_an), 32'd0);
        check_output("seg_only_with_an", 32'(bad_seg), 32'd0);

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i].s, vecs[i].f, vecs[i].so, vecs[i].bcd, vecs[i].neg);
            check_display(vecs[i].bcd, vecs[i].neg);
        end

        // Busy rejection: a request mid-conversion is dropped, not queued.
        @(negedge clk); Sel = 1'b0; flag = 1'b0; So = 8'h07; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); So = 8'h09; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_output("reject_bcd_edge10", 32'(bcd_out), 32'h007);
        check_output("reject_busy_edge10", 32'(busy), 32'd0);
        @(negedge clk); in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        check_output("recapture_busy_edge11", 32'(busy), 32'd1);
        repeat (9) @(posedge clk);
        #1;
        check_output("recapture_bcd_edge20", 32'(bcd_out), 32'h007);
        @(posedge clk); #1;
        check_output("recapture_bcd_edge21", 32'(bcd_out), 32'h009);
        prev_bcd = 12'h009;

        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom); rf = 1'($urandom); rso = 8'($urandom);
            model(rs, rf, rso, mb, mn);
            apply_stimulus(rs, rf, rso, mb, mn);
            if (i % 4 == 0) check_display(mb, mn);
        end

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk); Sel = 1'b0; flag = 1'b1; So = 8'h10; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        check_output("midshift_reset_busy", 32'(busy), 32'd0);
        check_output("midshift_reset_bcd", 32'(bcd_out), 32'd0);
        check_output("midshift_reset_neg", 32'(neg_out), 32'd0);
        check_output("midshift_reset_seg", 32'(seg), 32'h7f);
        check_output("midshift_reset_an", 32'(an), 32'hf);
        repeat (3) @(posedge clk);
        #1;
        check_output("held_reset_an", 32'(an), 32'hf);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("post_reset_an", 32'(an), 32'b1110);
        check_output("post_reset_busy", 32'(busy), 32'd0);
        prev_bcd = 12'h000;
        model(1'b1, 1'b1, 8'hF6, mb, mn);
        apply_stimulus(1'b1, 1'b1, 8'hF6, mb, mn);
        check_display(mb, mn);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
